// File: rtl/alu_uart_requester.sv
// rtl/alu_uart_requester.sv - host-side initiator for the ALU-over-UART command protocol
//
// Takes one command (op_code, data_a, data_b) on a start/busy/done handshake.
// It writes the command as three bytes into a UART TX FIFO and then pops one
// result byte from the UART RX FIFO.
//
// Optional feature macro: TIMEOUT_EN
//   When defined, WAIT_RES gives up after TIMEOUT_CYCLES empty cycles and
//   pulses timeout_err.
//   When undefined, WAIT_RES waits forever and timeout_err is tied 0.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               command request, sampled only while busy=0
//   op_code/data_a/b    command fields, latched when start is accepted
//   busy                transaction in progress
//   done                one-cycle pulse, result valid
//   result              last received result byte (low NB_AB bits)
//   timeout_err         one-cycle pulse, no result in time (TIMEOUT_EN)
//   w_data, wr_uart     TX FIFO write data / one-cycle write strobe
//   tx_full             TX FIFO full
//   r_data, rx_empty    RX FIFO head byte / empty flag
//   rd_uart             one-cycle RX FIFO pop strobe
module alu_uart_requester #(
    parameter int DBIT           = 8,
    parameter int NB_OP          = 6,
    parameter int NB_AB          = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NB_OP-1:0] op_code,
    input  logic [NB_AB-1:0] data_a,
    input  logic [NB_AB-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic [NB_AB-1:0] result,
    output logic             timeout_err,
    output logic [DBIT-1:0]  w_data,
    output logic             wr_uart,
    input  logic             tx_full,
    input  logic [DBIT-1:0]  r_data,
    input  logic             rx_empty,
    output logic             rd_uart
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_OP  = 3'd1,
        SEND_A   = 3'd2,
        SEND_B   = 3'd3,
        GAP      = 3'd4,
        WAIT_RES = 3'd5
    } state_t;

    state_t             state_q, state_d;
    state_t             ret_q, ret_d;       // state to resume after GAP
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_AB-1:0]   a_q, a_d;
    logic [NB_AB-1:0]   b_q, b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [NB_AB-1:0]   result_q, result_d;
    logic [DBIT-1:0]    w_data_q, w_data_d;
    logic               wr_q, wr_d;
    logic               rd_q, rd_d;

`ifdef TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               tmo_q, tmo_d;
`endif

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        w_data_d = w_data_q;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
`ifdef TIMEOUT_EN
        cnt_d    = cnt_q;
        tmo_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op_code;
                    a_d     = data_a;
                    b_d     = data_b;
                    busy_d  = 1'b1;
                    state_d = SEND_OP;
                end
            end
            SEND_OP: begin
                if (!tx_full) begin
                    w_data_d = DBIT'(op_q);
                    wr_d     = 1'b1;
                    ret_d    = SEND_A;
                    state_d  = GAP;
                end
            end
            SEND_A: begin
                if (!tx_full) begin
                    w_data_d = DBIT'(a_q);
                    wr_d     = 1'b1;
                    ret_d    = SEND_B;
                    state_d  = GAP;
                end
            end
            SEND_B: begin
                if (!tx_full) begin
                    w_data_d = DBIT'(b_q);
                    wr_d     = 1'b1;
                    ret_d    = WAIT_RES;
                    state_d  = GAP;
                end
            end
            GAP: begin
                // One idle cycle lets tx_full catch up with the write just issued.
                state_d = ret_q;
`ifdef TIMEOUT_EN
                if (ret_q == WAIT_RES) cnt_d = '0;
`endif
            end
            WAIT_RES: begin
                // Data arriving on the last timeout cycle still wins.
                if (!rx_empty) begin
                    result_d = r_data[NB_AB-1:0];
                    rd_d     = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
`ifdef TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ret_q    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            w_data_q <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
`ifdef TIMEOUT_EN
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            w_data_q <= w_data_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
`ifdef TIMEOUT_EN
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign w_data  = w_data_q;
    assign wr_uart = wr_q;
    assign rd_uart = rd_q;
`ifdef TIMEOUT_EN
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_uart_requester.sv
// tb/tb_alu_uart_requester.sv - directed self-checking bench for alu_uart_requester
module tb_alu_uart_requester;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] op_code;
    logic [7:0] data_a, data_b;
    logic       busy, done, timeout_err, wr_uart, tx_full, rx_empty, rd_uart;
    logic [7:0] result, w_data, r_data;

    int errors = 0;
    int checks = 0;

    // per-transaction log, in cycles counted from the start edge (cycle 0)
    int          cyc;
    logic [31:0] wq[$];
    logic [31:0] wc[$];
    logic [31:0] done_cyc, tmo_cyc;
    int          rd_cnt, done_cnt, tmo_cnt, b2b_cnt;
    logic        prev_wr;

    alu_uart_requester #(
        .DBIT(8), .NB_OP(6), .NB_AB(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .op_code(op_code), .data_a(data_a), .data_b(data_b),
        .busy(busy), .done(done), .result(result), .timeout_err(timeout_err),
        .w_data(w_data), .wr_uart(wr_uart), .tx_full(tx_full),
        .r_data(r_data), .rx_empty(rx_empty), .rd_uart(rd_uart)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wq.delete();
        wc.delete();
        done_cyc = 32'hFFFF; tmo_cyc = 32'hFFFF;
        rd_cnt = 0; done_cnt = 0; tmo_cnt = 0; b2b_cnt = 0;
        prev_wr = 1'b0;
        cyc = 0;
    endtask

    // Advance one clock, sample 1 ns after the edge, log pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (wr_uart) begin
            wq.push_back(32'(w_data));
            wc.push_back(32'(cyc));
        end
        if (wr_uart && prev_wr) b2b_cnt++;
        prev_wr = wr_uart;
        if (rd_uart) rd_cnt++;
        if (done) begin done_cnt++; done_cyc = 32'(cyc); end
        if (timeout_err) begin tmo_cnt++; tmo_cyc = 32'(cyc); end
    endtask

    // Issue start for one edge; that edge becomes cycle 0.
    task automatic issue(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        clear_log();
        start = 1'b1; op_code = op; data_a = a; data_b = b;
        tick();
        start = 1'b0;
        clear_log();
    endtask

    task automatic chk_bytes(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int c0, input int c1, input int c2);
        logic [31:0] eb[3];
        logic [31:0] ec[3];
        eb[0] = 32'(b0); eb[1] = 32'(b1); eb[2] = 32'(b2);
        ec[0] = 32'(c0); ec[1] = 32'(c1); ec[2] = 32'(c2);
        chk({tag, "_nwr"}, 32'(wq.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), (i < wq.size()) ? wq[i] : 32'hDEAD, eb[i]);
            chk($sformatf("%s_cyc%0d", tag, i), (i < wc.size()) ? wc[i] : 32'hDEAD, ec[i]);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; op_code = 6'h3F; data_a = 8'hAA; data_b = 8'h55;
        tx_full = 1'b0; rx_empty = 1'b1; r_data = 8'h00;
        clear_log();

        // reset with start held: reset wins, start is lost
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_wdata", 32'(w_data), 32'd0);
        chk("rst_wr", 32'(wr_uart), 32'd0);
        chk("rst_rd", 32'(rd_uart), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        reset = 1'b0; start = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);

        // basic command, RX byte already waiting
        rx_empty = 1'b0; r_data = 8'h08;
        issue(6'h20, 8'h05, 8'h03);
        chk("t1_busy", 32'(busy), 32'd1);
        repeat (7) tick();
        chk_bytes("t1", 8'h20, 8'h05, 8'h03, 1, 3, 5);
        chk("t1_done_cyc", done_cyc, 32'd7);
        chk("t1_busy_at_done", 32'(busy), 32'd0);
        chk("t1_result", 32'(result), 32'h08);
        repeat (3) tick();
        chk("t1_rd_cnt", 32'(rd_cnt), 32'd1);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);

        // TX stalled for 10 cycles, plus an ignored start while busy
        rx_empty = 1'b1; tx_full = 1'b1;
        issue(6'h11, 8'h22, 8'h33);
        for (int i = 1; i <= 10; i++) begin
            start = (i == 4);
            if (i == 4) begin op_code = 6'h22; data_a = 8'h99; data_b = 8'h77; end
            tick();
        end
        start = 1'b0;
        chk("t2_no_wr_full", 32'(wq.size()), 32'd0);
        chk("t2_wdata_hold", 32'(w_data), 32'h03);
        tx_full = 1'b0;
        repeat (6) tick();
        rx_empty = 1'b0; r_data = 8'h5A;
        tick();
        chk_bytes("t2", 8'h11, 8'h22, 8'h33, 11, 13, 15);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_result", 32'(result), 32'h5A);
        chk("t2_b2b", 32'(b2b_cnt), 32'd0);
        tick();
        chk("t2_extra_wr", 32'(wq.size()), 32'd3);

        // reset while in SEND_A
        rx_empty = 1'b1;
        issue(6'h01, 8'h02, 8'h03);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_wr", 32'(wr_uart), 32'd0);
        chk("t4_result", 32'(result), 32'd0);
        reset = 1'b0;
        repeat (6) tick();
        chk("t4_nwr", 32'(wq.size()), 32'd1);
        chk("t4_busy_idle", 32'(busy), 32'd0);
        rx_empty = 1'b0; r_data = 8'hC4;
        issue(6'h3F, 8'hFF, 8'h80);
        repeat (7) tick();
        chk_bytes("t4b", 8'h3F, 8'hFF, 8'h80, 1, 3, 5);
        chk("t4b_done_cyc", done_cyc, 32'd7);
        chk("t4b_result", 32'(result), 32'hC4);

        // back-to-back: second start in the done cycle
        r_data = 8'h11;
        issue(6'h02, 8'h10, 8'h20);
        repeat (7) tick();
        chk("t6_done1", 32'(done), 32'd1);
        chk("t6_result1", 32'(result), 32'h11);
        start = 1'b1; op_code = 6'h03; data_a = 8'h30; data_b = 8'h40; r_data = 8'h22;
        tick();
        start = 1'b0;
        chk("t6_busy2", 32'(busy), 32'd1);
        repeat (7) tick();
        chk("t6_nwr", 32'(wq.size()), 32'd6);
        chk("t6_wr2_cyc", (wc.size() > 3) ? wc[3] : 32'hDEAD, 32'd9);
        chk("t6_byte3", (wq.size() > 3) ? wq[3] : 32'hDEAD, 32'h03);
        chk("t6_byte5", (wq.size() > 5) ? wq[5] : 32'hDEAD, 32'h40);
        chk("t6_done_cnt", 32'(done_cnt), 32'd2);
        chk("t6_done2_cyc", done_cyc, 32'd15);
        chk("t6_result2", 32'(result), 32'h22);

        // no response: timeout (TIMEOUT_CYCLES=16) or indefinite wait
        rx_empty = 1'b1;
        issue(6'h05, 8'h06, 8'h07);
        repeat (30) tick();
        chk("t5_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("t5_result", 32'(result), 32'h22);
`ifdef TIMEOUT_EN
        chk("t5_tmo_cnt", 32'(tmo_cnt), 32'd1);
        chk("t5_tmo_cyc", tmo_cyc, 32'd22);
        chk("t5_busy", 32'(busy), 32'd0);
`else
        chk("t5_tmo_cnt", 32'(tmo_cnt), 32'd0);
        chk("t5_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_busy", 32'(busy), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_uart_requester.md
Name: alu_uart_requester

Overview:
- Host-side initiator for the ALU-over-UART command protocol.
- Accepts one command (op_code, data_a, data_b) on a start/busy/done port.
- Sends it as three bytes into a UART TX FIFO, then waits for one result byte from a UART RX FIFO and returns it.
- Sits between a test/host controller and a uart core (tx FIFO write side, rx FIFO read side); used in loopback benches and board self-test.

Parameters:
- DBIT, 8, UART data bits per byte
- NB_OP, 6, op_code width (NB_OP <= DBIT)
- NB_AB, 8, operand/result width (NB_AB <= DBIT)
- TIMEOUT_CYCLES, 1000000, cycles to wait for the result byte before aborting (only with TIMEOUT_EN)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  command request, sampled only when busy=0
- op_code  input  NB_OP  operation code, latched on accepted start
- data_a  input  NB_AB  operand A, latched on accepted start
- data_b  input  NB_AB  operand B, latched on accepted start
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse, result valid
- result  output  NB_AB  last received result
- timeout_err  output  1  one-cycle pulse, result not received in time
- w_data  output  DBIT  byte to UART TX FIFO
- wr_uart  output  1  one-cycle TX FIFO write strobe
- tx_full  input  1  TX FIFO full
- r_data  input  DBIT  head byte of UART RX FIFO
- rx_empty  input  1  RX FIFO empty
- rd_uart  output  1  one-cycle RX FIFO pop strobe

Behaviour:
- Single clock domain. Reset is synchronous and active-high, on clk; all outputs registered.
- Reset values: busy=0, done=0, result=0, timeout_err=0, w_data=0, wr_uart=0, rd_uart=0; state=IDLE; latched operands=0; timeout counter=0.
- Wire format, in order:
  - byte0 = op_code zero-extended to DBIT
  - byte1 = data_a zero-extended
  - byte2 = data_b zero-extended
  - response = one byte; result = r_data[NB_AB-1:0], upper bits ignored.
- States: IDLE, SEND_OP, SEND_A, SEND_B, GAP, WAIT_RES.
- IDLE: on an edge with start=1, latch the operands, busy<=1, go to SEND_OP. start is ignored while busy=1.
- SEND_x: on an edge with tx_full=0, w_data<=byte, wr_uart<=1 (high exactly one cycle), go to GAP; the return target is the next send state, or WAIT_RES after SEND_B. With tx_full=1, hold; w_data holds its last value.
- GAP: one cycle with wr_uart=0, so tx_full reflects the write just issued. wr_uart is never high on consecutive cycles.
- WAIT_RES: on an edge with rx_empty=0:
  - result<=r_data[NB_AB-1:0], rd_uart<=1 (one cycle), done<=1 (one cycle), busy<=0, go to IDLE.
  - An RX byte already present on entry is consumed as the result; the host flushes stale RX data before start.
- Latency: with tx_full=0 and rx_empty=0 throughout, wr_uart pulses in cycles 1, 3 and 5 after the start edge, and done/rd_uart pulse in cycle 7. busy deasserts in the same cycle done asserts.
- A new start is accepted in the cycle done is high (busy=0), giving back-to-back transactions.
- result holds its value until the next done or reset; it is unchanged on timeout.
- Reset mid-transaction: abort immediately, all outputs to reset values, and no further bytes are written. Bytes already written remain in the TX FIFO; flushing them is the system's responsibility.
- Simultaneous start and reset: reset wins, start is lost.
- tx_full=1 indefinitely: block stalls in the send state, with no timeout applied to the TX side.

Optional Feature:
- Macro TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT_RES and increments each cycle with rx_empty=1. When the counter equals TIMEOUT_CYCLES-1 and rx_empty=1: timeout_err<=1 for one cycle, busy<=0, go to IDLE, with no rd_uart. If data arrives on that same edge, data wins and done is pulsed, not timeout_err.
- Undefined: no counter; WAIT_RES waits indefinitely; timeout_err tied 0.

Test Plan:
- tx_full=0, start with op_code=6'h20, a=8'h05, b=8'h03; RX model returns 8'h08 → w_data sequence 8'h20, 8'h05, 8'h03 on wr_uart in cycles 1, 3, 5; done in cycle 7; result=8'h08; rd_uart exactly one pulse.
- tx_full held 1 for 10 cycles after the start edge, then 0 → first wr_uart occurs only after tx_full falls; no wr_uart while full; byte order unchanged.
- start pulsed again while busy (op=6'h22) → ignored; only the first command's 3 bytes are sent.
- reset asserted during SEND_A → next cycle busy=0, wr_uart=0, result=0; no further writes; a fresh command then completes normally.
- TIMEOUT_EN, TIMEOUT_CYCLES=16, rx_empty stays 1 → timeout_err pulses 16 cycles after WAIT_RES entry; rd_uart never asserts; result unchanged.
- Back-to-back: second start in the done cycle → second byte triple begins with wr_uart one cycle later; both results returned in order.
